program_encoder: RTL
====================

PROGRAM_ENCODER -- requirements
Module: program_encoder

Parameters
REQ-001 ADDR_STEP, default 1: added to the write address after every emitted word.

Interface
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  loads the write address from start_addr; honoured only in IDLE.
REQ-005 start_addr  input  16  first instruction-memory address to write.
REQ-006 in_valid  input  1  an instruction request is present.
REQ-007 in_ready  output  1  the encoder can accept a request this cycle.
REQ-008 in_op  input  4  major opcode: 1=get, 2=pop, 3=put, 4=call, 5=jumpf, 6=jump, 7=jumpt, 8=push, 0=no-argument group.
REQ-009 in_ext  input  4  extended opcode, used when in_op=0: 1 add, 2 lt, 3 sub, 4 and, 5 or, 6 xor, 7 dup, 8 ret, 9 sys, A load, B store, C test.
REQ-010 in_immed  input  16  immediate, register index or target address.
REQ-011 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-012 mem_addr  output  16  write address.
REQ-013 mem_data  output  16  encoded instruction word.
REQ-014 err  output  1  one-cycle pulse on a rejected request.
REQ-015 overflow  output  1  sticky flag: the write address wrapped past 16'hFFFF.
REQ-016 word_count  output  16  words written since reset; saturates at 16'hFFFF.

Function
REQ-017 FSM states: IDLE, EMIT_PRE and EMIT_INST. in_ready=1 in IDLE and in EMIT_INST, and 0 in EMIT_PRE.
REQ-018 A request is accepted on a rising edge with in_valid=1 and in_ready=1. Its fields are latched on that edge.
REQ-019 No-argument request (in_op=0, in_ext 1..C): word = {4'h0, 8'h00, in_ext}; next state EMIT_INST.
REQ-020 Register requests (in_op 1..3): in_immed must be below 512, else the request is rejected. Accepted word = {in_op, in_immed[11:0]}; next state EMIT_INST.
REQ-021 Value and address requests (in_op 4..8): a prefix is needed when in_immed[15:11] is neither 5'b00000 nor 5'b11111.
REQ-022 When a prefix is needed: prefix word = {4'hF, 8'h00, in_immed[15:12]}, followed by {in_op, in_immed[11:0]}; next state EMIT_PRE. Otherwise the single word is emitted; next state EMIT_INST.
REQ-023 Rejected request: err=1 for one cycle, no write, state remains IDLE. Rejection covers in_op 9..F, in_ext 0 or D..F when in_op=0, and the REQ-020 range violation.
REQ-024 EMIT_PRE: mem_we=1 with the prefix word for one cycle, then EMIT_INST.
REQ-025 EMIT_INST: mem_we=1 with the instruction word for one cycle. Next state is IDLE, or the next request's state if one is accepted in the same cycle (back-to-back).
REQ-026 Latency: the first word appears on mem_we/mem_addr/mem_data in the cycle after acceptance. Outputs are registered.
REQ-027 After each write, address += ADDR_STEP modulo 2^16. A wrap from a value >= 16'hFFFF-ADDR_STEP+1 sets overflow, which is cleared only by reset.
REQ-028 A two-word instruction that crosses the wrap point is still written completely (FFFF then 0000 for ADDR_STEP=1).
REQ-029 Simultaneous start and in_valid in IDLE: start_addr takes effect and is the address of the accepted request's first word.
REQ-030 start outside IDLE is ignored.
REQ-031 mem_we is never asserted in IDLE unless EMIT_INST is being exited in the same cycle.

Reset
REQ-032 Asserting reset immediately forces: state IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_data=0, err=0, overflow=0, word_count=0, write address=0.
REQ-033 Reset mid-instruction (for example in EMIT_PRE, or between the prefix and the instruction word) abandons the remaining word; no further write occurs.

Verification
REQ-034 start, start_addr=0010; push 0005 -> one write: addr 0010, data 8005; word_count=1.
REQ-035 push 1234 at address A -> two writes on consecutive cycles: F001 at A, then 8234 at A+1; in_ready=0 during the prefix cycle.
REQ-036 push FFF0 -> single write 8FF0. jump 0800 -> F000 then 6800.
REQ-037 op=0, ext=1 -> write 0001. op=0, ext=D -> err pulse, no write, word_count unchanged. get 0200 -> err.
REQ-038 start_addr=FFFF; push 1234 -> F001 at FFFF, then 8234 at 0000; overflow=1.
REQ-039 reset asserted in the cycle after the prefix write -> no instruction-word write; all outputs at their reset values.

Source files
------------

// File: rtl/program_encoder_if.sv
// program_encoder_if
// Groups the request channel and the instruction-memory write bus of the
// program encoder.
//   Request channel (master drives, slave accepts):
//     in_valid, in_op[3:0], in_ext[3:0], in_immed[15:0] -> slave
//     in_ready                                          <- slave
//   Memory write bus (slave drives):
//     mem_we, mem_addr[15:0], mem_data[15:0]
// Handshake: a request transfers on a rising clock edge where in_valid and
// in_ready are both 1. The master holds the request fields stable while
// in_valid is high. in_ready does not depend on in_valid.
interface program_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [3:0]  in_ext;
  logic [15:0] in_immed;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;

  modport master (
    output in_valid, in_op, in_ext, in_immed,
    input  in_ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  in_valid, in_op, in_ext, in_immed,
    output in_ready, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/program_encoder.sv
// program_encoder
// Turns instruction requests into 16-bit instruction-memory words. Value and
// address operations whose immediate does not fit in a sign-extended 12-bit
// field get a prefix word carrying immed[15:12] ahead of the instruction.
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   start          load the write address from start_addr (IDLE only)
//   start_addr     first instruction-memory address to write
//   bus            request channel + memory write bus (slave modport)
//   err            one-cycle pulse when a request is rejected
//   overflow       sticky: the write address wrapped past 16'hFFFF
//   word_count     words written since reset, saturating
//   state_dbg      current FSM state
module program_encoder #(
  parameter logic [15:0] ADDR_STEP = 16'd1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             start_addr,
  program_encoder_if.slave        bus,
  output logic                    err,
  output logic                    overflow,
  output logic [15:0]             word_count,
  output logic [1:0]              state_dbg
);

  // The state names the word currently presented on the memory bus:
  // IDLE nothing, EMIT_PRE the prefix word, EMIT_INST the instruction word.
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] EMIT_PRE  = 2'd1;
  localparam logic [1:0] EMIT_INST = 2'd2;

  logic [1:0]  state, state_d;
  logic [15:0] wr_addr;    // address of the next word to be written
  logic [15:0] inst_q;     // instruction word held while the prefix is out

  logic        req_ok, req_pre;
  logic [15:0] pre_word, inst_word;
  logic [4:0]  immed_hi;
  logic        accept;
  logic [15:0] base_addr;
  logic        emit;
  logic [15:0] emit_addr, emit_data;
  logic [16:0] step_sum;

  assign state_dbg    = state;
  assign bus.in_ready = (state != EMIT_PRE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign immed_hi     = bus.in_immed[15:11];

  // start only matters in IDLE, where it also redirects a request accepted
  // in the same cycle.
  assign base_addr = (state == IDLE && start) ? start_addr : wr_addr;

  // Request decode.
  always_comb begin
    req_ok    = 1'b0;
    req_pre   = 1'b0;
    inst_word = {bus.in_op, bus.in_immed[11:0]};
    pre_word  = {4'hF, 8'h00, bus.in_immed[15:12]};
    case (bus.in_op)
      4'd0: begin
        req_ok    = (bus.in_ext >= 4'h1) && (bus.in_ext <= 4'hC);
        inst_word = {12'h000, bus.in_ext};
      end
      4'd1, 4'd2, 4'd3: begin
        req_ok = (bus.in_immed < 16'd512);
      end
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
        req_ok = 1'b1;
        // Immediates whose top five bits are all equal fit as a
        // sign-extended 12-bit value and need no prefix.
        req_pre = (immed_hi != 5'b00000) && (immed_hi != 5'b11111);
      end
      default: ;
    endcase
  end

  // Next word to put on the bus, if any.
  always_comb begin
    emit      = 1'b0;
    emit_addr = wr_addr;
    emit_data = inst_q;
    state_d   = IDLE;
    if (state == EMIT_PRE) begin
      emit    = 1'b1;
      state_d = EMIT_INST;
    end else if (accept && req_ok) begin
      emit      = 1'b1;
      emit_addr = base_addr;
      emit_data = req_pre ? pre_word : inst_word;
      state_d   = req_pre ? EMIT_PRE : EMIT_INST;
    end
  end

  // Carry out of the 17-bit sum marks an address wrap.
  assign step_sum = {1'b0, emit_addr} + {1'b0, ADDR_STEP};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_addr    <= 16'h0000;
      inst_q     <= 16'h0000;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= 16'h0000;
      bus.mem_data <= 16'h0000;
      err        <= 1'b0;
      overflow   <= 1'b0;
      word_count <= 16'h0000;
    end else begin
      state      <= state_d;
      err        <= accept && !req_ok;
      bus.mem_we <= emit;
      if (accept && req_ok) begin
        inst_q <= inst_word;
      end
      if (emit) begin
        bus.mem_addr <= emit_addr;
        bus.mem_data <= emit_data;
        wr_addr      <= step_sum[15:0];
        if (step_sum[16]) begin
          overflow <= 1'b1;
        end
        if (word_count != 16'hFFFF) begin
          word_count <= word_count + 16'd1;
        end
      end else begin
        wr_addr <= base_addr;
      end
    end
  end

endmodule
